// File: rtl/alu_issue_ctl_if.sv
// Command and result handshake bundle for alu_issue_ctl.
// Master issues commands and drains results; slave is the controller.
interface alu_issue_ctl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_chain;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a,
    output cmd_b, cmd_chain, res_ready,
    input  cmd_ready, res_valid,
    input  res_data, res_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a,
    input  cmd_b, cmd_chain, res_ready,
    output cmd_ready, res_valid,
    output res_data, res_err
  );
endinterface

// File: rtl/alu_issue_ctl.sv
// Issue controller for the registered 8-bit ALU.
// Drives A/B/CTR, waits out ALU_LAT, returns O with an error flag.
module alu_issue_ctl #(
  parameter int ALU_LAT = 2
) (
  input  logic       ck,
  input  logic       rst,
  alu_issue_ctl_if.slave bus,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_ctr,
  input  logic [7:0] alu_o
);

  localparam int CW =
    (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [7:0]    last;
  logic [7:0]    rdata;
  logic          rvalid;
  logic          rerr;
  logic          legal;
  logic          take;

  // Opcodes 0000, 0001 and 1xxx exist in the ALU.
  assign legal = bus.cmd_op[3]
               | (bus.cmd_op[3:1] == 3'b000);

  // Ready depends on state only.
  assign bus.cmd_ready = (state == IDLE);
  assign take = bus.cmd_valid & bus.cmd_ready;

  assign bus.res_valid = rvalid;
  assign bus.res_data  = rdata;
  assign bus.res_err   = rerr;

  // Issue, wait for the ALU pipeline, hold result until drained.
  always_ff @(posedge ck) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= 8'h00;
      rdata   <= 8'h00;
      rvalid  <= 1'b0;
      rerr    <= 1'b0;
      alu_a   <= 8'h00;
      alu_b   <= 8'h00;
      alu_ctr <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (take && legal) begin
            alu_a   <= bus.cmd_chain ? last
                                     : bus.cmd_a;
            alu_b   <= bus.cmd_b;
            alu_ctr <= bus.cmd_op;
            cnt     <= CW'(ALU_LAT);
            state   <= WAIT;
          end else if (take) begin
            rdata  <= 8'h00;
            rerr   <= 1'b1;
            rvalid <= 1'b1;
            state  <= DONE;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rdata  <= alu_o;
            rerr   <= 1'b0;
            rvalid <= 1'b1;
            last   <= alu_o;
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            rvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctl.sv
// Randomized bench for alu_issue_ctl with a behavioural ALU
// and a transaction-level model of the controller.
module tb_alu_issue_ctl;

  logic       ck = 1'b0;
  logic       rst;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_ctr;
  logic [7:0] alu_o;
  logic [7:0] p1 = 8'h00;
  logic [7:0] p2 = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] last_m = 8'h00;
  logic [7:0] a_m = 8'h00;
  logic [7:0] b_m = 8'h00;
  logic [3:0] c_m = 4'h0;
  logic [7:0] got_data;

  alu_issue_ctl_if bus ();

  alu_issue_ctl #(.ALU_LAT(2)) dut (
    .ck      (ck),
    .rst     (rst),
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_ctr (alu_ctr),
    .alu_o   (alu_o)
  );

  always #5 ck = ~ck;

  function automatic logic [7:0] alu_f(
    input logic [3:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h8: return a & b;
      4'h9: return a | b;
      4'hA: return a ^ b;
      4'hB: return ~a;
      4'hC: return a >> 1;
      4'hD: return a << 1;
      4'hE: return {a[0], a[7:1]};
      4'hF: return {a[6:0], a[7]};
      default: return 8'h00;
    endcase
  endfunction

  // Two-stage registered ALU.
  always @(posedge ck) begin
    p1 <= alu_f(alu_ctr, alu_a, alu_b);
    p2 <= p1;
  end
  assign alu_o = p2;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic junk();
    bus.cmd_valid = 1'($urandom_range(0, 1));
    bus.cmd_op    = 4'($urandom);
    bus.cmd_a     = 8'($urandom);
    bus.cmd_b     = 8'($urandom);
    bus.cmd_chain = 1'($urandom_range(0, 1));
  endtask

  task automatic do_op(
    input logic [3:0] op,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       ch,
    input int         hold
  );
    logic       lg;
    logic [7:0] av;
    logic [7:0] exp;
    int         n;
    lg  = (op == 4'h0) || (op == 4'h1) || (op >= 4'h8);
    av  = ch ? last_m : a;
    exp = lg ? alu_f(op, av, b) : 8'h00;
    chk("rdy_idle", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_chain = ch;
    @(posedge ck); #1;
    junk();
    if (lg) begin
      a_m = av;
      b_m = b;
      c_m = op;
    end
    chk("alu_a", 32'(alu_a), 32'(a_m));
    chk("alu_b", 32'(alu_b), 32'(b_m));
    chk("alu_ctr", 32'(alu_ctr), 32'(c_m));
    n = 0;
    while (!bus.res_valid && n < 10) begin
      chk("wait_rdy", 32'(bus.cmd_ready), 0);
      @(posedge ck); #1;
      junk();
      n++;
      chk("hold_a", 32'(alu_a), 32'(a_m));
      chk("hold_ctr", 32'(alu_ctr), 32'(c_m));
    end
    chk("latency", n, lg ? 3 : 0);
    chk("res_data", 32'(bus.res_data), 32'(exp));
    chk("res_err", 32'(bus.res_err), 32'(!lg));
    got_data = bus.res_data;
    repeat (hold) begin
      chk("bp_rdy", 32'(bus.cmd_ready), 0);
      @(posedge ck); #1;
      junk();
      chk("bp_vld", 32'(bus.res_valid), 1);
      chk("bp_data", 32'(bus.res_data), 32'(exp));
      chk("bp_err", 32'(bus.res_err), 32'(!lg));
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge ck); #1;
    bus.res_ready = 1'b0;
    chk("drop_vld", 32'(bus.res_valid), 0);
    chk("rdy_back", 32'(bus.cmd_ready), 1);
    if (lg) last_m = exp;
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'h0;
    bus.cmd_a     = 8'h00;
    bus.cmd_b     = 8'h00;
    bus.cmd_chain = 1'b0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge ck);
    #1;
    chk("rst_rdy", 32'(bus.cmd_ready), 1);
    chk("rst_vld", 32'(bus.res_valid), 0);
    chk("rst_err", 32'(bus.res_err), 0);
    chk("rst_data", 32'(bus.res_data), 0);
    chk("rst_a", 32'(alu_a), 0);
    chk("rst_ctr", 32'(alu_ctr), 0);
    rst = 1'b0;

    do_op(4'h0, 8'h35, 8'h12, 1'b0, 0);
    chk("tp_add", 32'(got_data), 32'h47);
    do_op(4'h1, 8'h10, 8'h20, 1'b0, 1);
    chk("tp_sub", 32'(got_data), 32'hF0);
    do_op(4'hF, 8'h81, 8'h5A, 1'b0, 0);
    chk("tp_rol", 32'(got_data), 32'h03);
    do_op(4'h0, 8'h05, 8'h03, 1'b0, 0);
    chk("tp_ch0", 32'(got_data), 32'h08);
    do_op(4'hD, 8'hFF, 8'h00, 1'b1, 0);
    chk("tp_chain", 32'(got_data), 32'h10);
    do_op(4'h4, 8'h77, 8'h66, 1'b0, 0);
    chk("tp_ill", 32'(got_data), 32'h00);
    do_op(4'h0, 8'hFF, 8'h01, 1'b1, 0);
    chk("tp_ch_ill", 32'(got_data), 32'h11);
    do_op(4'h9, 8'h0F, 8'hF0, 1'b0, 5);
    chk("tp_bp", 32'(got_data), 32'hFF);

    // Reset one cycle after an accept.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'h0;
    bus.cmd_a     = 8'h11;
    bus.cmd_b     = 8'h22;
    bus.cmd_chain = 1'b0;
    @(posedge ck); #1;
    bus.cmd_valid = 1'b0;
    @(posedge ck); #1;
    rst = 1'b1;
    @(posedge ck); #1;
    rst = 1'b0;
    last_m = 8'h00;
    a_m = 8'h00;
    b_m = 8'h00;
    c_m = 4'h0;
    chk("mrst_rdy", 32'(bus.cmd_ready), 1);
    chk("mrst_vld", 32'(bus.res_valid), 0);
    chk("mrst_data", 32'(bus.res_data), 0);
    chk("mrst_a", 32'(alu_a), 0);
    chk("mrst_b", 32'(alu_b), 0);
    chk("mrst_ctr", 32'(alu_ctr), 0);
    repeat (6) begin
      @(posedge ck); #1;
      chk("mrst_nores", 32'(bus.res_valid), 0);
    end
    do_op(4'h0, 8'hAA, 8'h22, 1'b1, 0);
    chk("tp_after_rst", 32'(got_data), 32'h22);

    for (int i = 0; i < 60; i++) begin
      do_op(4'($urandom_range(0, 15)),
            8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)),
            $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
